priority_encoder_dual: RTL and testbench

- Parameterised priority encoder over a WIDTH-bit request vector.
- Reports the index of the most-significant set bit, optionally the least-significant set bit, and a valid flag.
- Used by the rename stage to pick the next free physical tag from the free-pool bit vector; the rename stage consumes out_MSB in the same cycle.
- Optional output register for timing-critical instances.

---
 rtl/priority_encoder_dual_pkg.sv | 9 +
 rtl/priority_encoder_dual_if.sv | 13 +
 rtl/pe_merge_node.sv | 27 ++
 rtl/priority_encoder_dual.sv | 96 +++++++++
 tb/tb_priority_encoder_dual.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/priority_encoder_dual_pkg.sv
// Shared helpers for the dual-sided priority encoder: padded tree width.
package priority_encoder_dual_pkg;

  // Leaf count of the merge tree: WIDTH rounded up to a power of two.
  function automatic int unsigned pe_pad_width(input int unsigned w);
    return 32'd1 << $clog2(w);
  endfunction

endpackage

// File: rtl/priority_encoder_dual_if.sv
// Request vector and encoded results of priority_encoder_dual.
interface priority_encoder_dual_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned OUT_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0] in;
  logic [OUT_W-1:0] out_MSB;
  logic [OUT_W-1:0] out_LSB;
  logic             valid;

  modport master (output in, input out_MSB, out_LSB, valid);
  modport slave  (input in, output out_MSB, out_LSB, valid);
endinterface

// File: rtl/pe_merge_node.sv
// Combinational 2:1 merge of two priority-encoder subtrees.
module pe_merge_node #(
  parameter int unsigned IDX_W     = 0,
  parameter bit          PREFER_HI = 1'b1,
  localparam int unsigned CW       = (IDX_W > 0) ? IDX_W : 1
) (
  input  logic          valid_hi,
  input  logic [CW-1:0] idx_hi,
  input  logic          valid_lo,
  input  logic [CW-1:0] idx_lo,
  output logic          valid,
  output logic [IDX_W:0] idx
);
  logic sel;

  // With both children empty sel stays 0, so empty subtrees yield index 0.
  assign sel   = PREFER_HI ? valid_hi : (valid_hi & ~valid_lo);
  assign valid = valid_hi | valid_lo;

  if (IDX_W == 0) begin : g_leaf
    logic unused_idx;
    assign unused_idx = ^{idx_hi, idx_lo};
    assign idx        = sel;
  end else begin : g_inner
    assign idx = {sel, sel ? idx_hi : idx_lo};
  end
endmodule

// File: rtl/priority_encoder_dual.sv
// Log-depth MSB/LSB priority encoder with optional registered outputs.
module priority_encoder_dual
  import priority_encoder_dual_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter bit          TWO_SIDE = 1'b0,
  parameter bit          OUT_REG  = 1'b0,
  parameter int unsigned OUT_W    = $clog2(WIDTH)
) (
  input logic                   clk,
  input logic                   rst,
  priority_encoder_dual_if.slave bus
);
  localparam int unsigned PAD_W  = pe_pad_width(WIDTH);
  localparam int unsigned N_TREE = TWO_SIDE ? 2 : 1;

  logic [PAD_W-1:0] leaf;
  logic [OUT_W-1:0] comb_msb;
  logic [OUT_W-1:0] comb_lsb;
  logic             comb_v;

  // Padding bits are zero so they can never win either tree.
  assign leaf = PAD_W'(bus.in);

  // Tree 0 prefers the high child (MSB); tree 1 prefers the low child (LSB).
  for (genvar t = 0; t < N_TREE; t++) begin : g_tree
    for (genvar k = 1; k <= OUT_W; k++) begin : g_lvl
      localparam int unsigned N  = PAD_W >> k;
      localparam int unsigned CW = (k > 1) ? k - 1 : 1;
      logic [N-1:0] v;
      logic [k-1:0] idx [N];

      for (genvar j = 0; j < N; j++) begin : g_node
        logic          vh;
        logic          vl;
        logic [CW-1:0] ih;
        logic [CW-1:0] il;

        if (k == 1) begin : g_from_leaf
          assign vh = leaf[2*j+1];
          assign vl = leaf[2*j];
          assign ih = '0;
          assign il = '0;
        end else begin : g_from_lvl
          assign vh = g_lvl[k-1].v[2*j+1];
          assign vl = g_lvl[k-1].v[2*j];
          assign ih = g_lvl[k-1].idx[2*j+1];
          assign il = g_lvl[k-1].idx[2*j];
        end

        pe_merge_node #(
          .IDX_W     (k - 1),
          .PREFER_HI (t == 0)
        ) u_node (
          .valid_hi (vh),
          .idx_hi   (ih),
          .valid_lo (vl),
          .idx_lo   (il),
          .valid    (v[j]),
          .idx      (idx[j])
        );
      end
    end
  end

  assign comb_msb = g_tree[0].g_lvl[OUT_W].idx[0];
  assign comb_v   = g_tree[0].g_lvl[OUT_W].v[0];

  if (TWO_SIDE) begin : g_lsb
    logic unused_lsb_v;
    assign unused_lsb_v = g_tree[1].g_lvl[OUT_W].v[0];
    assign comb_lsb     = g_tree[1].g_lvl[OUT_W].idx[0];
  end else begin : g_no_lsb
    assign comb_lsb = '0;
  end

  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bus.out_MSB <= '0;
        bus.out_LSB <= '0;
        bus.valid   <= 1'b0;
      end else begin
        bus.out_MSB <= comb_msb;
        bus.out_LSB <= comb_lsb;
        bus.valid   <= comb_v;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign bus.out_MSB    = comb_msb;
    assign bus.out_LSB    = comb_lsb;
    assign bus.valid      = comb_v;
  end
endmodule

// File: tb/tb_priority_encoder_dual.sv
// Directed and random checks of priority_encoder_dual in four configurations.
module tb_priority_encoder_dual;

  typedef struct packed {
    logic [5:0] msb;
    logic [5:0] lsb;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  priority_encoder_dual_if #(.WIDTH(64)) i0 ();
  priority_encoder_dual_if #(.WIDTH(64)) i1 ();
  priority_encoder_dual_if #(.WIDTH(5))  i2 ();
  priority_encoder_dual_if #(.WIDTH(64)) i3 ();

  priority_encoder_dual #(.WIDTH(64), .TWO_SIDE(1'b1), .OUT_REG(1'b0))
    u_d0 (.clk(clk), .rst(rst), .bus(i0.slave));
  priority_encoder_dual #(.WIDTH(64), .TWO_SIDE(1'b0), .OUT_REG(1'b0))
    u_d1 (.clk(clk), .rst(rst), .bus(i1.slave));
  priority_encoder_dual #(.WIDTH(5), .TWO_SIDE(1'b1), .OUT_REG(1'b0))
    u_d2 (.clk(clk), .rst(rst), .bus(i2.slave));
  priority_encoder_dual #(.WIDTH(64), .TWO_SIDE(1'b1), .OUT_REG(1'b1))
    u_d3 (.clk(clk), .rst(rst), .bus(i3.slave));

  // Reference: plain linear scan of the request bits.
  function automatic exp_t model(input logic [63:0] x, input int unsigned w, input bit ts);
    exp_t e = '0;
    for (int unsigned i = 0; i < w; i++)
      if (x[i]) begin
        e.v   = 1'b1;
        e.msb = 6'(i);
      end
    if (ts)
      for (int unsigned i = w; i > 0; i--)
        if (x[i-1]) e.lsb = 6'(i - 1);
    return e;
  endfunction

  function automatic logic [63:0] rand_vec(input int unsigned sel);
    logic [63:0] x = {$urandom, $urandom};
    case (sel % 4)
      0: rand_vec = x;
      1: rand_vec = x >> $urandom_range(0, 63);
      2: rand_vec = 64'd1 << $urandom_range(0, 63);
      default: rand_vec = x & {$urandom, $urandom} & {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(input string tag, input logic [5:0] msb, input logic [5:0] lsb,
                       input logic v);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s scoreboard empty, no expected value", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (v === e.v) passed++;
    else $error("FAIL %s valid got %b expected %b", tag, v, e.v);
    checks++;
    assert (msb === e.msb) passed++;
    else $error("FAIL %s out_MSB got %0d expected %0d", tag, msb, e.msb);
    checks++;
    assert (lsb === e.lsb) passed++;
    else $error("FAIL %s out_LSB got %0d expected %0d", tag, lsb, e.lsb);
  endtask

  task automatic step_d0(input string tag, input logic [63:0] x);
    i0.in = x;
    sb.push_back(model(x, 64, 1'b1));
    #1;
    check(tag, i0.out_MSB, i0.out_LSB, i0.valid);
  endtask

  task automatic step_d1(input string tag, input logic [63:0] x);
    i1.in = x;
    sb.push_back(model(x, 64, 1'b0));
    #1;
    check(tag, i1.out_MSB, i1.out_LSB, i1.valid);
  endtask

  task automatic step_d2(input string tag, input logic [4:0] x);
    i2.in = x;
    sb.push_back(model({59'd0, x}, 5, 1'b1));
    #1;
    check(tag, {3'd0, i2.out_MSB}, {3'd0, i2.out_LSB}, i2.valid);
  endtask

  task automatic sample_d3(input string tag);
    check(tag, i3.out_MSB, i3.out_LSB, i3.valid);
  endtask

  initial begin
    logic [63:0] x;
    i0.in = '0;
    i1.in = '0;
    i2.in = '0;
    i3.in = '0;
    #1;

    // Combinational, two-sided, 64 bits (rst held high: must be ignored)
    step_d0("d0_zero", 64'd0);
    step_d0("d0_63_32", (64'd1 << 63) | (64'd1 << 32));
    step_d0("d0_bit0", 64'd1);
    step_d0("d0_ones", '1);
    step_d0("d0_bit63", 64'd1 << 63);
    for (int unsigned i = 0; i < 200; i++) step_d0("d0_rand", rand_vec(i));

    // MSB-only instance: out_LSB tied to 0
    step_d1("d1_pool", 64'hFFFF_FFFF_0000_0000);
    step_d1("d1_pool_clr", 64'h0FFF_FFFF_0000_0000);
    step_d1("d1_zero", 64'd0);
    step_d1("d1_mid", 64'h0000_0100_0000_0010);

    // Non-power-of-two width
    step_d2("d2_10100", 5'b10100);
    step_d2("d2_00010", 5'b00010);
    step_d2("d2_zero", 5'b00000);
    step_d2("d2_top", 5'b10000);
    step_d2("d2_ones", 5'b11111);
    for (int unsigned i = 0; i < 100; i++) begin
      x = rand_vec(i);
      step_d2("d2_rand", x[4:0]);
    end

    // Registered instance
    @(negedge clk);
    sb.push_back('0);
    sample_d3("d3_in_reset");
    x = (64'd1 << 40) | (64'd1 << 3);
    i3.in = x;
    rst = 1'b0;
    #1;
    sb.push_back('0);
    sample_d3("d3_before_edge");
    @(posedge clk);
    #1;
    sb.push_back(model(x, 64, 1'b1));
    sample_d3("d3_first");
    #2;
    rst = 1'b1;
    #1;
    sb.push_back('0);
    sample_d3("d3_async_rst");
    @(posedge clk);
    #1;
    sb.push_back('0);
    sample_d3("d3_rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.push_back('0);
    sample_d3("d3_release_no_edge");
    @(posedge clk);
    #1;
    sb.push_back(model(x, 64, 1'b1));
    sample_d3("d3_recover");

    for (int unsigned i = 0; i < 1000; i++) begin
      @(negedge clk);
      x = rand_vec(i);
      i3.in = x;
      sb.push_back(model(x, 64, 1'b1));
      @(posedge clk);
      #1;
      sample_d3("d3_rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
